iram_loader: RTL and testbench
==============================

// Module: iram_loader
// PURPOSE
//  Boot-time controller for the instruction memory write port. Receives a byte
//  stream (length header + 16-bit words, high byte first) over a valid/ready
//  handshake and writes each word into the instruction memory. Holds the CPU
//  in reset (CPU_HOLD) until a load completes, then releases it.
// PARAMETERS
//  DEPTH  128  instruction words in memory (2..256)
//  AW     7    word-address width, $clog2(DEPTH)
// PORTS
//  CLK         in   1   system clock, rising edge
//  RESET       in   1   asynchronous reset, active-low
//  START       in   1   1-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
//  BYTE_IN     in   8   stream byte
//  BYTE_VALID  in   1   BYTE_IN valid
//  BYTE_READY  out  1   loader accepts a byte this cycle
//  WE          out  1   instruction-memory write strobe, 1 cycle per word
//  WADDR       out  AW  word address being written
//  WDATA       out  16  word being written, {hi,lo}
//  CPU_HOLD    out  1   1 = keep CPU in reset
//  DONE        out  1   load finished successfully
//  ERR         out  1   load aborted (bad length / checksum)
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE; CPU_HOLD=1; BYTE_READY=WE=DONE=ERR=0;
//    WADDR=0; WDATA=0; word counter=0; checksum=0.
//  - Byte transfer occurs on a rising edge with BYTE_VALID & BYTE_READY.
//    BYTE_READY=1 exactly in LEN, HI, LO, CSUM; registered state decode, no
//    combinational path from BYTE_VALID.
//  - FSM:  IDLE --START--> LEN (clear counter, checksum, DONE, ERR)
//          LEN  --xfer--> HI;  N = BYTE_IN, N==0 means DEPTH;
//                          N>DEPTH (nonzero) --> ERR
//          HI   --xfer--> LO;  latch hi byte
//          LO   --xfer--> next cycle WE=1, WADDR=count, WDATA={hi,BYTE_IN};
//                          count+1; if count+1==N -> CSUM (macro) / DONE,
//                          else HI
//          CSUM --xfer--> DONE if BYTE_IN==checksum, else ERR
//          DONE: DONE=1, CPU_HOLD=0; START -> LEN (CPU_HOLD=1 same edge)
//          ERR : ERR=1, CPU_HOLD=1; START -> LEN
//  - WE/WADDR/WDATA registered: 1-cycle latency after the LO byte; WE
//    deasserts the following cycle unless another LO transfer occurred.
//    Minimum 2 cycles/byte not required: back-to-back bytes accepted every cycle.
//  - START in LEN/HI/LO/CSUM ignored; START and a byte in the same cycle in
//    DONE/ERR: byte not accepted (BYTE_READY=0 there).
//  - Counter is AW+1 bits so N==DEPTH terminates without wrap; WADDR never
//    exceeds DEPTH-1.
//  - CPU_HOLD=1 in every state except DONE. Reset mid-load returns to IDLE,
//    partially written words are left in memory, CPU stays held.
//  - Checksum: 8-bit modulo-256 sum of all data bytes (hi and lo), excluding
//    the length byte.
// CONFIGURATION
//  IRAM_LOADER_CHECKSUM_EN defined: CSUM state present; one trailing byte after
//   the last word is compared with the checksum; mismatch -> ERR (CPU held).
//  Not defined: CSUM state and checksum register omitted; LO of last word goes
//   straight to DONE; ERR only from bad length.
// TESTING
//  1 Reset: RESET=0 mid-cycle -> immediately CPU_HOLD=1, WE=DONE=ERR=0,
//    BYTE_READY=0; START ignored while RESET=0.
//  2 START, bytes 02,11,22,33,44 back-to-back -> WE addr0=1122 then addr1=3344,
//    DONE=1, CPU_HOLD=0 (with macro: send 0xAA sum byte first).
//  3 Same stream with BYTE_VALID toggling 1/0 each cycle -> identical writes,
//    exactly 2 WE pulses, no WE on idle cycles.
//  4 Length 0x00, DEPTH=128 -> 128 writes, WADDR 0..127, no wrap, DONE; length
//    0x81 -> ERR=1 next cycle, no WE, CPU_HOLD=1.
//  5 Macro on: 01,10,20 then 0x31 -> ERR=1, CPU_HOLD=1; START, 01,10,20,0x30 ->
//    DONE=1.
//  6 RESET during HI of word 3 -> IDLE, CPU_HOLD=1; fresh load completes normally.

Source files
------------

// File: rtl/iram_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The slave modport is the loader; the master side feeds bytes and takes the writes.
interface iram_loader_if #(
  parameter int AW = 7
);
  logic [7:0]    byte_data;
  logic          valid;
  logic          ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;

  modport master (
    output byte_data, valid,
    input  ready, we, waddr, wdata
  );

  modport slave (
    input  byte_data, valid,
    output ready, we, waddr, wdata
  );
endinterface

// File: rtl/iram_loader.sv
// Boot loader: length byte + big-endian 16-bit words into instruction memory, CPU held until done.
// Optional trailing modulo-256 checksum byte when IRAM_LOADER_CHECKSUM_EN is defined.
module iram_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  iram_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [8:0]    DEPTH_9 = 9'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
`ifdef IRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd6;
  logic [7:0] csum;
`endif

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] n_words;
  logic [CW-1:0] count_next;
  logic [7:0]    hi_byte;
  logic [8:0]    len_9;
  logic          xfer;

  assign count_next = count + CW'(1);
  assign len_9      = {1'b0, bus.byte_data};
  assign xfer       = bus.valid & bus.ready;

  // Ready is a pure decode of the registered state, never of valid.
  always_comb begin
    bus.ready = (state == S_LEN) || (state == S_HI) || (state == S_LO);
`ifdef IRAM_LOADER_CHECKSUM_EN
    if (state == S_CSUM) bus.ready = 1'b1;
`endif
  end

  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      n_words   <= '0;
      hi_byte   <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      bus.we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LEN;
            count <= '0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        S_LEN: begin
          if (xfer) begin
            // A zero length byte stands for a full memory image.
            if (len_9 > DEPTH_9) begin
              state <= S_ERR;
            end else begin
              n_words <= (len_9 == 9'd0) ? DEPTH_C : CW'(len_9);
              state   <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= bus.byte_data;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum    <= csum + bus.byte_data;
`endif
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            bus.we    <= 1'b1;
            bus.waddr <= count[AW-1:0];
            bus.wdata <= {hi_byte, bus.byte_data};
            count     <= count_next;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum      <= csum + bus.byte_data;
            state     <= (count_next == n_words) ? S_CSUM : S_HI;
`else
            state     <= (count_next == n_words) ? S_DONE : S_HI;
`endif
          end
        end
`ifdef IRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) state <= (bus.byte_data == csum) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: a stream-level model predicts every memory write
// and the final outcome; a monitor compares each WE cycle, directed tests pin literals.
module tb_iram_loader;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  iram_loader_if #(.AW(AW)) bus ();

  iram_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  wr_t seen_q[$];

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && bus.we !== 1'b0) begin
      seen_q.push_back('{int'(bus.waddr), bus.wdata});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_we: got addr=%0d data=%h, required no write", bus.waddr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.we !== 1'b1 || int'(bus.waddr) != e.addr || bus.wdata !== e.data) begin
          errors++;
          $display("[TB] FAIL write: got we=%b addr=%0d data=%h, required addr=%0d data=%h",
                   bus.we, bus.waddr, bus.wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Stream-level model: words come from byte pairs after the length byte.
  task automatic modelStream(input logic [7:0] b[$], output logic exp_done, output logic exp_err);
    int n;
    logic [7:0] sum;
    n = (b[0] == 8'd0) ? DEPTH : int'(b[0]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    sum      = 8'd0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n && 2 * i + 2 < b.size(); i++) begin
      exp_q.push_back('{i, {b[2*i+1], b[2*i+2]}});
      sum = sum + b[2*i+1] + b[2*i+2];
    end
`ifdef IRAM_LOADER_CHECKSUM_EN
    if (b.size() < 2 * n + 2) return;
    if (b[2*n+1] == sum) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    if (b.size() < 2 * n + 1) return;
    exp_done = 1'b1;
`endif
  endtask

  function automatic logic [7:0] sumOf(input logic [7:0] b[$]);
    logic [7:0] s = 8'd0;
    for (int i = 1; i < b.size(); i++) s = s + b[i];
    return s;
  endfunction

  // Appends the checksum byte only in builds that expect one.
  function automatic void addSum(ref logic [7:0] b[$]);
`ifdef IRAM_LOADER_CHECKSUM_EN
    b.push_back(sumOf(b));
`endif
  endfunction

  task automatic startLoad();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b[$], input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < b.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (toggle && (cyc % 2 == 0)) begin
        bus.valid = 1'b0;
        hs = 1'b0;
      end else begin
        bus.valid     = 1'b1;
        bus.byte_data = b[idx];
        #1;
        hs = (bus.ready === 1'b1);
      end
      @(posedge clk);
      if (hs) idx++;
    end
    @(negedge clk);
    bus.valid = 1'b0;
    checkVal("bytes_accepted", idx, b.size());
  endtask

  task automatic checkOutput(input string name, input logic exp_done, input logic exp_err);
    repeat (2) @(negedge clk);
    #1;
    checkVal({name, "_done"}, done, exp_done);
    checkVal({name, "_err"}, err, exp_err);
    checkVal({name, "_hold"}, cpu_hold, !exp_done);
    checkVal({name, "_ready"}, bus.ready, 1'b0);
    checkVal({name, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] b[$];
    logic ed, ee;
    bus.valid     = 1'b0;
    bus.byte_data = 8'h00;

    // Reset held: START ignored, outputs at reset values.
    #3 start = 1'b1;
    #10 start = 1'b0;
    #1;
    checkVal("rst_hold", cpu_hold, 1'b1);
    checkVal("rst_ready", bus.ready, 1'b0);
    checkVal("rst_we", bus.we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("idle_ready", bus.ready, 1'b0);
    checkVal("idle_done", done, 1'b0);
    checkVal("idle_err", err, 1'b0);

    // Basic two-word load.
    b = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    addSum(b);
    seen_q.delete();
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    checkOutput("basic", ed, ee);
    checkVal("basic_model_done", ed, 1'b1);
    checkVal("basic_nwrites", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      checkVal("basic_w0", {seen_q[0].addr[15:0], seen_q[0].data}, 32'h0000_1122);
      checkVal("basic_w1", {seen_q[1].addr[15:0], seen_q[1].data}, 32'h0001_3344);
    end
`ifdef IRAM_LOADER_CHECKSUM_EN
    checkVal("basic_sum", sumOf(b[0:4]), 8'hAA);
`endif

    // Asynchronous reset mid-cycle out of DONE.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("async_hold", cpu_hold, 1'b1);
    checkVal("async_done", done, 1'b0);
    checkVal("async_we", bus.we, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("async_idle_ready", bus.ready, 1'b0);

    // Same stream with valid toggling every cycle.
    seen_q.delete();
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b1);
    checkOutput("toggle", ed, ee);
    checkVal("toggle_nwrites", seen_q.size(), 2);

    // START with a byte in DONE: byte must not be taken.
    b.delete();
    b.push_back(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      b.push_back(8'(i));
      b.push_back(~8'(i));
    end
    addSum(b);
    seen_q.delete();
    modelStream(b, ed, ee);
    @(negedge clk);
    start         = 1'b1;
    bus.valid     = 1'b1;
    bus.byte_data = 8'h00;
    #1;
    checkVal("start_byte_ready", bus.ready, 1'b0);
    @(negedge clk);
    start     = 1'b0;
    bus.valid = 1'b0;
    applyStimulus(b, 1'b0);
    checkOutput("full", ed, ee);
    checkVal("full_nwrites", seen_q.size(), DEPTH);
    if (seen_q.size() == DEPTH)
      checkVal("full_last", {seen_q[DEPTH-1].addr[15:0], seen_q[DEPTH-1].data}, 32'h007F_7F80);

    // Oversize length.
    b = '{8'h81};
    seen_q.delete();
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    #1;
    checkVal("oversize_err_next", err, 1'b1);
    checkOutput("oversize", ed, ee);
    checkVal("oversize_nwrites", seen_q.size(), 0);

`ifdef IRAM_LOADER_CHECKSUM_EN
    b = '{8'h01, 8'h10, 8'h20, 8'h31};
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    checkOutput("badsum", ed, ee);
    checkVal("badsum_err", err, 1'b1);
    b = '{8'h01, 8'h10, 8'h20, 8'h30};
`else
    b = '{8'h01, 8'h10, 8'h20};
`endif
    seen_q.delete();
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    checkOutput("single", ed, ee);
    checkVal("single_done", done, 1'b1);
    if (seen_q.size() == 1)
      checkVal("single_w0", {seen_q[0].addr[15:0], seen_q[0].data}, 32'h0000_1020);
    else
      checkVal("single_nwrites", seen_q.size(), 1);

    // Reset while waiting for the high byte of the third word.
    b = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    #1;
    checkVal("partial_ready", bus.ready, 1'b1);
    checkVal("partial_hold", cpu_hold, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("partial_rst_hold", cpu_hold, 1'b1);
    checkVal("partial_rst_ready", bus.ready, 1'b0);
    checkVal("partial_writes_left", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    b = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    addSum(b);
    seen_q.delete();
    modelStream(b, ed, ee);
    startLoad();
    applyStimulus(b, 1'b0);
    checkOutput("reload", ed, ee);
    checkVal("reload_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
